blocks_collider: RTL and testbench
==================================

# blocks_collider

Owns the brick-wall state that the block renderer reads.
- Once per frame it tests the four corners of the ball's bounding box against the live blocks.
- It clears every block that is hit and reports which way the ball must bounce.
- It drives the `block_state` vector consumed by the drawer, and the hit/bounce pulses consumed by the ball controller.
- All work completes within a few dozen clocks after `new_frame`, well inside vertical blanking.

## Interface
Parameters:
- `BORDER_WIDTH`, 8, pixel offset of the wall from the left and top screen edges
- `BLOCK_WIDTH`, 48, block width in pixels
- `BLOCK_HEIGHT`, 16, block height in pixels
- `BLOCKS_PER_ROW`, 13, columns
- `NUM_ROWS`, 1, rows; N = `BLOCKS_PER_ROW`*`NUM_ROWS`
- `BALL_SIZE`, 8, ball edge length in pixels

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system/pixel clock
- `rst` in 1: asynchronous, active-high reset
- `new_frame` in 1: one-cycle strobe that starts a check; the ball position is sampled on this cycle
- `ball_x` in 10: ball left pixel column
- `ball_y` in 9: ball top pixel line
- `restore` in 1: synchronous strobe that reloads all blocks (new game)
- `block_state` out N: 1 = block present; bit index = row*`BLOCKS_PER_ROW`+col
- `hit` out 1: one-cycle pulse, at least one block cleared
- `bounce_x` out 1: one-cycle pulse with `hit`, reverse horizontal velocity
- `bounce_y` out 1: one-cycle pulse with `hit`, reverse vertical velocity
- `busy` out 1: check in progress
- `cleared` out 1: level; `block_state` is all zero

## Operation
Reset values:
- `block_state` = all ones
- `hit`, `bounce_x`, `bounce_y`, `busy` = 0
- `cleared` = 0
- FSM in IDLE

Corners, in evaluation order:
- c0 TL = (x, y)
- c1 TR = (x+`BALL_SIZE`-1, y)
- c2 BL = (x, y+`BALL_SIZE`-1)
- c3 BR = (x+`BALL_SIZE`-1, y+`BALL_SIZE`-1)

Corner arithmetic uses 11-bit sums, so there is no wrap.

FSM:
- IDLE: on `new_frame`, latch `ball_x`/`ball_y`, clear the corner mask and clear mask, then go to LOAD with corner 0.
- LOAD: form rel_x = cx-`BORDER_WIDTH` and rel_y = cy-`BORDER_WIDTH`, and zero col/row.
  - If the corner is outside the wall region, it is a miss: go to NEXT logic in the same cycle (advance the corner, or go to APPLY after c3).
  - Otherwise go to DIV_X.
  - Wall region is `BORDER_WIDTH` ≤ cx < `BORDER_WIDTH`+`BLOCKS_PER_ROW`*`BLOCK_WIDTH`, and the same on y with `NUM_ROWS`*`BLOCK_HEIGHT`.
- DIV_X: while rel_x ≥ `BLOCK_WIDTH`, subtract `BLOCK_WIDTH` and increment col (one per cycle). In the cycle rel_x < `BLOCK_WIDTH`, go to DIV_Y.
- DIV_Y: same scheme on rel_y with `BLOCK_HEIGHT` and row; then go to TEST.
- TEST: idx = row*`BLOCKS_PER_ROW`+col.
  - If `block_state[idx]`, set the corner bit and clear-mask bit idx.
  - Advance to LOAD of the next corner, or go to APPLY after c3.
- APPLY:
  - `block_state` &= ~clear mask.
  - `hit` = (clear mask ≠ 0).
  - Pulse the bounce outputs per the rules below.
  - Return to IDLE.

Bounce rules (on corner mask):
- ty = TL&TR; by = BL&BR; lx = TL&BL; rx = TR&BR.
- `bounce_y` = hit & (ty | by | exactly one corner set).
- `bounce_x` = hit & (lx | rx) & ~ty & ~by.
- Corners landing in the same block clear it once.

Boundary cases:
- `new_frame` while busy: ignored.
- `restore` (any state): `block_state` = all ones, FSM → IDLE, pending check discarded, no pulses.
- `restore` and `new_frame` in the same cycle: `restore` wins, no check starts.
- `rst` mid-check: all state returns to reset values.
- `cleared` = ~|`block_state`, registered from the new value.

## Timing
- `busy` rises the cycle after `new_frame` and falls in the cycle after APPLY.
- Cost per corner:
  - outside region: 1 cycle (LOAD);
  - inside region: 1 + (col+1) + (row+1) + 1 cycles.
- Ball fully outside: `busy` high exactly 5 cycles (4 LOAD + APPLY).
- Worst case (defaults): 4*(1+13+1+1)+1 = 65 cycles.
- `hit`/`bounce_*` are high exactly one cycle: the cycle after the APPLY edge. `block_state` updates on that same edge.
- `block_state` is otherwise static, so the drawer may sample it at any time.

## Configuration
- `BLOCKS_SCORE_EN` defined:
  - adds output `score` (8 bits, reset 0);
  - on APPLY, adds popcount(clear mask) (1 or 2), saturating at 255;
  - `restore` zeroes it.
- `BLOCKS_SCORE_EN` undefined: `score` port and counter are absent; all other behaviour is identical.

## Test plan
- After reset, ball (114,4) + `new_frame`: BL/BR land in col 2 → bit 2 cleared (`block_state`=13'h1FFB), `hit`=1, `bounce_y`=1, `bounce_x`=0; with the macro, `score`=1.
- Ball (52,20): TL/TR in cols 0 and 1, bottom corners below the wall → bits 0,1 cleared, `bounce_y`=1; with the macro, `score` +2.
- Repeat the first scenario with bit 2 already clear → `hit`=0, no bounce pulses, `block_state` unchanged.
- Ball (300,200) fully outside → `busy` high exactly 5 cycles, no pulses.
- Clear all 13 blocks → `cleared`=1; then `restore` → `block_state`=13'h1FFF, `cleared`=0, `score`=0.
- `restore` asserted during DIV_X of a hitting check → no `hit`, `busy`=0 the next cycle, all blocks present.

Source files
------------

// File: rtl/blocks_collider_if.sv
// Frame-check request/result bundle between the ball controller, block drawer and blocks_collider.
// BLOCKS_SCORE_EN adds the 8-bit score result.
interface blocks_collider_if #(
  parameter int unsigned N = 13
);
  logic         new_frame;
  logic [9:0]   ball_x;
  logic [8:0]   ball_y;
  logic         restore;
  logic [N-1:0] block_state;
  logic         hit;
  logic         bounce_x;
  logic         bounce_y;
  logic         busy;
  logic         cleared;
`ifdef BLOCKS_SCORE_EN
  logic [7:0]   score;

  modport master (
    output new_frame, ball_x, ball_y, restore,
    input  block_state, hit, bounce_x, bounce_y, busy, cleared, score
  );

  modport slave (
    input  new_frame, ball_x, ball_y, restore,
    output block_state, hit, bounce_x, bounce_y, busy, cleared, score
  );
`else
  modport master (
    output new_frame, ball_x, ball_y, restore,
    input  block_state, hit, bounce_x, bounce_y, busy, cleared
  );

  modport slave (
    input  new_frame, ball_x, ball_y, restore,
    output block_state, hit, bounce_x, bounce_y, busy, cleared
  );
`endif
endinterface

// File: rtl/blocks_collider.sv
// Brick-wall owner: per frame, tests the ball's four bounding-box corners against live blocks,
// clears hit blocks and pulses bounce directions. Optional score counter under BLOCKS_SCORE_EN.
module blocks_collider #(
  parameter int unsigned BORDER_WIDTH   = 8,
  parameter int unsigned BLOCK_WIDTH    = 48,
  parameter int unsigned BLOCK_HEIGHT   = 16,
  parameter int unsigned BLOCKS_PER_ROW = 13,
  parameter int unsigned NUM_ROWS       = 1,
  parameter int unsigned BALL_SIZE      = 8
) (
  input logic             clk,
  input logic             rst,
  blocks_collider_if.slave bus
);
  localparam int unsigned N     = BLOCKS_PER_ROW * NUM_ROWS;
  localparam int unsigned COL_W = $clog2(BLOCKS_PER_ROW + 1);
  localparam int unsigned ROW_W = $clog2(NUM_ROWS + 1);

  localparam logic [10:0] WALL_LO  = 11'(BORDER_WIDTH);
  localparam logic [10:0] WALL_XHI = 11'(BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH);
  localparam logic [10:0] WALL_YHI = 11'(BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT);
  localparam logic [10:0] BW       = 11'(BLOCK_WIDTH);
  localparam logic [10:0] BH       = 11'(BLOCK_HEIGHT);
  localparam logic [10:0] BALL_OFF = 11'(BALL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, TEST, APPLY} state_t;

  state_t           state;
  state_t           state_nxt;

  logic [9:0]       ball_x_q;
  logic [8:0]       ball_y_q;
  logic [1:0]       corner;
  logic [3:0]       corner_mask;
  logic [N-1:0]     clear_mask;
  logic [10:0]      rel_x;
  logic [10:0]      rel_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [10:0]      cx;
  logic [10:0]      cy;
  logic             corner_in;
  logic             last_corner;
  logic [31:0]      idx;
  logic [N-1:0]     idx_sel;

  logic [N-1:0]     block_state_q;
  logic [N-1:0]     block_state_nxt;
  logic             hit_q;
  logic             hit_nxt;
  logic             bounce_x_q;
  logic             bounce_x_nxt;
  logic             bounce_y_q;
  logic             bounce_y_nxt;
  logic             busy_q;
  logic             busy_nxt;
  logic             cleared_q;
  logic             cleared_nxt;

  logic             top_pair;
  logic             bot_pair;
  logic             left_pair;
  logic             right_pair;
  logic             single_corner;

  // Corner coordinates: bit 0 of the corner index selects the right edge, bit 1 the bottom edge.
  assign cx = {1'b0, ball_x_q} + (corner[0] ? BALL_OFF : 11'd0);
  assign cy = {2'b0, ball_y_q} + (corner[1] ? BALL_OFF : 11'd0);
  assign corner_in   = (cx >= WALL_LO) && (cx < WALL_XHI) && (cy >= WALL_LO) && (cy < WALL_YHI);
  assign last_corner = (corner == 2'd3);

  assign idx = 32'(row) * BLOCKS_PER_ROW + 32'(col);

  always_comb begin
    idx_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx_sel[i] = (idx == 32'(i));
    end
  end

  assign top_pair      = corner_mask[0] & corner_mask[1];
  assign bot_pair      = corner_mask[2] & corner_mask[3];
  assign left_pair     = corner_mask[0] & corner_mask[2];
  assign right_pair    = corner_mask[1] & corner_mask[3];
  assign single_corner = ($countones(corner_mask) == 1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; restore aborts any check and blocks a new one.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.new_frame) state_nxt = LOAD;
      LOAD:    if (corner_in)     state_nxt = DIV_X;
               else               state_nxt = last_corner ? APPLY : LOAD;
      DIV_X:   if (rel_x < BW)    state_nxt = DIV_Y;
      DIV_Y:   if (rel_y < BH)    state_nxt = TEST;
      TEST:    state_nxt = last_corner ? APPLY : LOAD;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.restore) state_nxt = IDLE;
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    block_state_nxt = block_state_q;
    hit_nxt         = 1'b0;
    bounce_x_nxt    = 1'b0;
    bounce_y_nxt    = 1'b0;
    busy_nxt        = (state_nxt != IDLE);
    if (bus.restore) begin
      block_state_nxt = '1;
    end else if (state == APPLY) begin
      block_state_nxt = block_state_q & ~clear_mask;
      hit_nxt         = |clear_mask;
      bounce_y_nxt    = hit_nxt & (top_pair | bot_pair | single_corner);
      bounce_x_nxt    = hit_nxt & (left_pair | right_pair) & ~top_pair & ~bot_pair;
    end
    cleared_nxt = ~|block_state_nxt;
  end

  // Corner walk datapath: repeated subtraction replaces division by block size.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      corner      <= '0;
      corner_mask <= '0;
      clear_mask  <= '0;
      rel_x       <= '0;
      rel_y       <= '0;
      col         <= '0;
      row         <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.new_frame) begin
          ball_x_q    <= bus.ball_x;
          ball_y_q    <= bus.ball_y;
          corner      <= '0;
          corner_mask <= '0;
          clear_mask  <= '0;
        end
        LOAD: begin
          rel_x <= cx - WALL_LO;
          rel_y <= cy - WALL_LO;
          col   <= '0;
          row   <= '0;
          if (!corner_in) corner <= corner + 2'd1;
        end
        DIV_X: if (rel_x >= BW) begin
          rel_x <= rel_x - BW;
          col   <= col + COL_W'(1);
        end
        DIV_Y: if (rel_y >= BH) begin
          rel_y <= rel_y - BH;
          row   <= row + ROW_W'(1);
        end
        TEST: begin
          if (|(idx_sel & block_state_q)) begin
            corner_mask[corner] <= 1'b1;
            clear_mask          <= clear_mask | idx_sel;
          end
          corner <= corner + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_state_q <= '1;
      hit_q         <= 1'b0;
      bounce_x_q    <= 1'b0;
      bounce_y_q    <= 1'b0;
      busy_q        <= 1'b0;
      cleared_q     <= 1'b0;
    end else begin
      block_state_q <= block_state_nxt;
      hit_q         <= hit_nxt;
      bounce_x_q    <= bounce_x_nxt;
      bounce_y_q    <= bounce_y_nxt;
      busy_q        <= busy_nxt;
      cleared_q     <= cleared_nxt;
    end
  end

  assign bus.block_state = block_state_q;
  assign bus.hit         = hit_q;
  assign bus.bounce_x    = bounce_x_q;
  assign bus.bounce_y    = bounce_y_q;
  assign bus.busy        = busy_q;
  assign bus.cleared     = cleared_q;

`ifdef BLOCKS_SCORE_EN
  logic [7:0] score_q;
  logic [7:0] hit_count;
  logic [8:0] score_sum;

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < int'(N); i++) begin
      hit_count = hit_count + 8'(clear_mask[i]);
    end
  end

  assign score_sum = {1'b0, score_q} + {1'b0, hit_count};

  // Saturating score, zeroed on a new game.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
    end else if (bus.restore) begin
      score_q <= '0;
    end else if (state == APPLY) begin
      score_q <= score_sum[8] ? 8'hFF : score_sum[7:0];
    end
  end

  assign bus.score = score_q;
`endif
endmodule

// File: tb/tb_blocks_collider.sv
// Self-checking bench for blocks_collider: frame-level behavioural model, per-cycle compare,
// directed scenarios with literal expectations and a randomized phase.
module tb_blocks_collider;
  localparam int NB     = 13;
  localparam int BORDER = 8;
  localparam int BW     = 48;
  localparam int BH     = 16;
  localparam int BPR    = 13;
  localparam int ROWS   = 1;
  localparam int BALL   = 8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic chk_en;

  blocks_collider_if #(.N(NB)) bus ();

  blocks_collider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: block wall, score, remaining busy cycles and the pending frame result.
  logic [NB-1:0] m_blocks;
  int            m_score;
  int            m_cnt;
  logic [NB-1:0] p_clr;
  logic          p_bx;
  logic          p_by;
  logic          e_hit;
  logic          e_bx;
  logic          e_by;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-frame result from geometry: returns clear set, bounce flags and busy length.
  task automatic model_frame(input int x, input int y, input logic [NB-1:0] blocks,
                             output logic [NB-1:0] clr, output logic bx, output logic by,
                             output int lat);
    logic [3:0] m;
    int cx, cy, col, row, idx;
    logic ty, byy, lx, rx, h;
    m = '0; clr = '0; lat = 1;
    for (int c = 0; c < 4; c++) begin
      cx = x + (((c & 1) != 0) ? BALL - 1 : 0);
      cy = y + (((c & 2) != 0) ? BALL - 1 : 0);
      if (cx >= BORDER && cx < BORDER + BPR * BW && cy >= BORDER && cy < BORDER + ROWS * BH) begin
        col = (cx - BORDER) / BW;
        row = (cy - BORDER) / BH;
        lat += 1 + (col + 1) + (row + 1) + 1;
        idx = row * BPR + col;
        if (blocks[idx]) begin
          m[c] = 1'b1;
          clr[idx] = 1'b1;
        end
      end else begin
        lat += 1;
      end
    end
    ty = m[0] & m[1]; byy = m[2] & m[3]; lx = m[0] & m[2]; rx = m[1] & m[3];
    h  = (clr != '0);
    by = h & (ty | byy | ($countones(m) == 1));
    bx = h & (lx | rx) & ~ty & ~byy;
  endtask

  always @(posedge clk or posedge rst) begin
    int lat;
    e_hit = 1'b0; e_bx = 1'b0; e_by = 1'b0;
    if (rst) begin
      m_blocks = '1; m_score = 0; m_cnt = 0;
    end else if (bus.restore) begin
      m_blocks = '1; m_score = 0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_blocks = m_blocks & ~p_clr;
        e_hit    = (p_clr != '0);
        e_bx     = p_bx;
        e_by     = p_by;
        m_score  = m_score + $countones(p_clr);
        if (m_score > 255) m_score = 255;
      end
    end else if (bus.new_frame) begin
      model_frame(int'(bus.ball_x), int'(bus.ball_y), m_blocks, p_clr, p_bx, p_by, lat);
      m_cnt = lat;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("block_state", 32'(bus.block_state), 32'(m_blocks));
      check("hit",         32'(bus.hit),         32'(e_hit));
      check("bounce_x",    32'(bus.bounce_x),    32'(e_bx));
      check("bounce_y",    32'(bus.bounce_y),    32'(e_by));
      check("busy",        32'(bus.busy),        32'(m_cnt > 0));
      check("cleared",     32'(bus.cleared),     32'(m_blocks == '0));
`ifdef BLOCKS_SCORE_EN
      check("score",       32'(bus.score),       32'(m_score));
`endif
    end
  end

  task automatic run_frame(input int x, input int y, output int bcyc,
                           output logic h, output logic bx, output logic by);
    bit done;
    @(posedge clk); #1;
    bus.ball_x = 10'(x); bus.ball_y = 9'(y); bus.new_frame = 1'b1;
    @(posedge clk); #1;
    bus.new_frame = 1'b0;
    bcyc = 0; h = 1'b0; bx = 1'b0; by = 1'b0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.busy) bcyc++;
      else begin
        h = bus.hit; bx = bus.bounce_x; by = bus.bounce_y; done = 1'b1;
      end
    end
    if (!done) check("frame_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_restore();
    @(posedge clk); #1; bus.restore = 1'b1;
    @(posedge clk); #1; bus.restore = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int   bc;
    logic h, bx, by;
    logic any_hit;
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    rst = 1'b1;
    bus.new_frame = 1'b0; bus.restore = 1'b0; bus.ball_x = '0; bus.ball_y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_block_state", 32'(bus.block_state), 32'h1FFF);
    check("rst_busy",        32'(bus.busy),        32'(0));
    check("rst_cleared",     32'(bus.cleared),     32'(0));

    // Bottom corners in column 2.
    run_frame(114, 4, bc, h, bx, by);
    check("t1_hit", 32'(h), 32'(1));
    check("t1_bounce_y", 32'(by), 32'(1));
    check("t1_bounce_x", 32'(bx), 32'(0));
    check("t1_block_state", 32'(bus.block_state), 32'h1FFB);
    check("t1_model_blocks", 32'(m_blocks), 32'h1FFB);
`ifdef BLOCKS_SCORE_EN
    check("t1_score", 32'(bus.score), 32'(1));
`endif

    // Top corners straddle columns 0 and 1.
    run_frame(52, 20, bc, h, bx, by);
    check("t2_hit", 32'(h), 32'(1));
    check("t2_bounce_y", 32'(by), 32'(1));
    check("t2_bounce_x", 32'(bx), 32'(0));
    check("t2_block_state", 32'(bus.block_state), 32'h1FF8);
`ifdef BLOCKS_SCORE_EN
    check("t2_score", 32'(bus.score), 32'(3));
`endif

    // Same spot again: block already gone.
    run_frame(114, 4, bc, h, bx, by);
    check("t3_hit", 32'(h), 32'(0));
    check("t3_bounce_y", 32'(by), 32'(0));
    check("t3_block_state", 32'(bus.block_state), 32'h1FF8);

    // Fully outside the wall.
    run_frame(300, 200, bc, h, bx, by);
    check("t4_busy_cycles", 32'(bc), 32'(5));
    check("t4_hit", 32'(h), 32'(0));

    // Clear every column, then restore.
    for (int c = 0; c < BPR; c++) run_frame(BORDER + BW * c + 10, 20, bc, h, bx, by);
    check("t5_block_state", 32'(bus.block_state), 32'h0);
    check("t5_cleared", 32'(bus.cleared), 32'(1));
    do_restore();
    check("t5_restore_state", 32'(bus.block_state), 32'h1FFF);
    check("t5_restore_cleared", 32'(bus.cleared), 32'(0));
`ifdef BLOCKS_SCORE_EN
    check("t5_restore_score", 32'(bus.score), 32'(0));
`endif

    // Restore while a hitting check is in DIV_X.
    @(posedge clk); #1;
    bus.ball_x = 10'(114); bus.ball_y = 9'(4); bus.new_frame = 1'b1;
    @(posedge clk); #1; bus.new_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.restore = 1'b1;
    @(posedge clk); #1 bus.restore = 1'b0;
    @(negedge clk);
    check("t6_busy", 32'(bus.busy), 32'(0));
    check("t6_block_state", 32'(bus.block_state), 32'h1FFF);
    any_hit = 1'b0;
    repeat (6) begin
      @(negedge clk);
      any_hit |= bus.hit;
    end
    check("t6_no_hit", 32'(any_hit), 32'(0));

    // Reset in the middle of a check.
    run_frame(114, 4, bc, h, bx, by);
    @(posedge clk); #1;
    bus.ball_x = 10'(52); bus.ball_y = 9'(20); bus.new_frame = 1'b1;
    @(posedge clk); #1; bus.new_frame = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t7_busy", 32'(bus.busy), 32'(0));
    check("t7_block_state", 32'(bus.block_state), 32'h1FFF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic; the compare process checks every cycle.
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      bus.new_frame = ($urandom_range(0, 3) == 0);
      bus.ball_x    = 10'($urandom_range(0, 680));
      bus.ball_y    = 9'($urandom_range(0, 40));
      bus.restore   = ($urandom_range(0, 299) == 0) || (bus.cleared && $urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    bus.new_frame = 1'b0; bus.restore = 1'b0;
    repeat (80) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
